// File: rtl/mc_alu_pkg.sv
// mc_alu_pkg: shared types and encodings for the multi-cycle ALU.
//   blk_e   : basic-op block select (op[3:2])
//   flag_e  : bit positions inside the 4-bit flags word
//   state_e : control FSM states
//   XSHL..XMUL : extended-op encodings (op[1:0] when ext=1)
package mc_alu_pkg;

    typedef enum logic [1:0] {
        ARITH = 2'd0,
        LOGIC = 2'd1,
        SHIFT = 2'd2,
        STRAY = 2'd3
    } blk_e;

    typedef enum logic [1:0] {
        C = 2'd0,
        Z = 2'd1,
        N = 2'd2,
        V = 2'd3
    } flag_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [1:0] XSHL = 2'b00;
    localparam logic [1:0] XSHR = 2'b01;
    localparam logic [1:0] XSAR = 2'b10;
    localparam logic [1:0] XMUL = 2'b11;

endpackage

// File: rtl/mc_alu_iter.sv
// mc_alu_iter: iterative engine for extended ops (multi-bit shifts, multiply).
//   clk, rst_n : clock, async active-low reset
//   load       : capture xop/a/b and the iteration count
//   step       : perform one iteration
//   xop        : extended op (XSHL/XSHR/XSAR/XMUL)
//   a, b       : shift source / multiplicand, shift amount / multiplier
//   last       : the current step is the final one
//   result     : value the accumulator will hold after the current step
//   carry      : carry flag that goes with result
module mc_alu_iter
    import mc_alu_pkg::*;
#(
    parameter int WORD = 16,
    parameter int SHW  = $clog2(WORD)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [1:0]      xop,
    input  logic [WORD-1:0] a,
    input  logic [WORD-1:0] b,
    output logic            last,
    output logic [WORD-1:0] result,
    output logic            carry
);

    // Counter must hold WORD itself for the multiply.
    localparam int CW = SHW + 1;

    logic [1:0]      xop_q;
    logic [CW-1:0]   cnt_q;
    logic [WORD-1:0] hi_q, lo_q, mcand_q;
    logic [WORD-1:0] hi_d, lo_d;
    logic            carry_d;
    logic [WORD:0]   sum;

    // Shifts work on lo alone. The multiply keeps the product in {hi,lo}
    // with the multiplier in lo: add mcand into hi when lo[0] is set, then
    // shift the whole {carry,hi,lo} right by one.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WORD+1){1'b0}});
        hi_d    = hi_q;
        lo_d    = lo_q;
        carry_d = 1'b0;
        case (xop_q)
            XSHL: begin
                lo_d    = {lo_q[WORD-2:0], 1'b0};
                carry_d = lo_q[WORD-1];
            end
            XSHR: begin
                lo_d    = {1'b0, lo_q[WORD-1:1]};
                carry_d = lo_q[0];
            end
            XSAR: begin
                lo_d    = {lo_q[WORD-1], lo_q[WORD-1:1]};
                carry_d = lo_q[0];
            end
            default: begin
                hi_d    = sum[WORD:1];
                lo_d    = {sum[0], lo_q[WORD-1:1]};
                carry_d = |sum[WORD:1];
            end
        endcase
    end

    assign last   = (cnt_q == CW'(1));
    assign result = lo_d;
    assign carry  = carry_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xop_q   <= XSHL;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
        end else if (load) begin
            xop_q   <= xop;
            cnt_q   <= (xop == XMUL) ? CW'(WORD) : CW'(b[SHW-1:0]);
            hi_q    <= '0;
            lo_q    <= (xop == XMUL) ? b : a;
            mcand_q <= a;
        end else if (step) begin
            cnt_q <= cnt_q - 1'b1;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

endmodule

// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU for the execute stage.
//   clk, rst_n   : clock, async active-low reset
//   start, ready : request / accept handshake (accepted when start & ready)
//   ext, op, cin : operation select and carry in
//   a, b         : operands (b[SHW-1:0] is the shift amount)
//   done         : one-cycle pulse when res/flags are updated
//   res, flags   : registered result and {V,N,Z,C}
// Basic ops finish on the accept edge; extended ops run in mc_alu_iter.
module mc_alu
    import mc_alu_pkg::*;
#(
    parameter int WORD = 16,
    parameter int SHW  = $clog2(WORD)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            ext,
    input  logic [3:0]      op,
    input  logic            cin,
    input  logic [WORD-1:0] a,
    input  logic [WORD-1:0] b,
    output logic            ready,
    output logic            done,
    output logic [WORD-1:0] res,
    output logic [3:0]      flags
);

    state_e          state_q, state_d;
    logic            load, step, upd_basic, upd_iter;
    logic            zero_shift;
    logic            iter_last, iter_c;
    logic [WORD-1:0] iter_res;
    logic [WORD-1:0] b_op;
    logic            ci;
    logic [WORD:0]   sum;
    logic [WORD-1:0] b_res;
    logic            b_c, b_v;

    // Subtract forms use ~b; the carry in is cin for odd codes, 1 for SUB.
    assign b_op = op[1] ? ~b : b;
    assign ci   = op[0] ? cin : op[1];
    assign sum  = {1'b0, a} + {1'b0, b_op} + {{WORD{1'b0}}, ci};

    // An extended shift of zero places finishes through the basic path.
    assign zero_shift = ext && (op[1:0] != XMUL) && (b[SHW-1:0] == '0);

    always_comb begin
        b_res = '0;
        b_c   = 1'b0;
        b_v   = 1'b0;
        if (ext) begin
            b_res = a;
        end else begin
            case (op[3:2])
                ARITH: begin
                    b_res = sum[WORD-1:0];
                    b_c   = sum[WORD];
                    b_v   = (a[WORD-1] == b_op[WORD-1]) && (sum[WORD-1] != a[WORD-1]);
                end
                LOGIC: begin
                    case (op[1:0])
                        2'b00:   b_res = a & b;
                        2'b01:   b_res = a | b;
                        2'b10:   b_res = a ^ b;
                        default: b_res = a & ~b;
                    endcase
                end
                SHIFT: begin
                    b_res = op[0] ? {a[WORD-1], a[WORD-1:1]} : {cin, a[WORD-1:1]};
                    b_c   = a[0];
                end
                default: begin
                    case (op[1:0])
                        2'b00:   b_res = b;
                        // Rotate by one byte: a plain byte swap at WORD=16.
                        2'b01:   b_res = (a << 8) | (a >> (WORD - 8));
                        2'b10:   b_res = {{(WORD-8){a[7]}}, a[7:0]};
                        default: b_res = ~a;
                    endcase
                end
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        step      = 1'b0;
        upd_basic = 1'b0;
        upd_iter  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ext && !zero_shift) begin
                        load    = 1'b1;
                        state_d = RUN;
                    end else begin
                        upd_basic = 1'b1;
                    end
                end
            end
            default: begin
                step = 1'b1;
                if (iter_last) begin
                    upd_iter = 1'b1;
                    state_d  = IDLE;
                end
            end
        endcase
    end

    assign ready = (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done  <= 1'b0;
            res   <= '0;
            flags <= '0;
        end else begin
            done <= upd_basic | upd_iter;
            if (upd_basic) begin
                res      <= b_res;
                flags[C] <= b_c;
                flags[Z] <= (b_res == '0);
                flags[N] <= b_res[WORD-1];
                flags[V] <= b_v;
            end else if (upd_iter) begin
                res      <= iter_res;
                flags[C] <= iter_c;
                flags[Z] <= (iter_res == '0);
                flags[N] <= iter_res[WORD-1];
                flags[V] <= 1'b0;
            end
        end
    end

    mc_alu_iter #(
        .WORD (WORD),
        .SHW  (SHW)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .xop    (op[1:0]),
        .a      (a),
        .b      (b),
        .last   (iter_last),
        .result (iter_res),
        .carry  (iter_c)
    );

endmodule

// File: tb/tb_mc_alu.sv
// tb_mc_alu: self-checking bench for mc_alu at WORD=16.
module tb_mc_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ext = 1'b0;
    logic [3:0]  op = 4'h0;
    logic        cin = 1'b0;
    logic [15:0] a = 16'h0;
    logic [15:0] b = 16'h0;
    logic        ready, done;
    logic [15:0] res;
    logic [3:0]  flags;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    mc_alu #(.WORD(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .ext   (ext),
        .op    (op),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .res   (res),
        .flags (flags)
    );

    typedef struct {
        logic        e;
        logic [3:0]  o;
        logic        ci;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] er;
        logic [3:0]  ef;
        int          el;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Reference model: results straight from the operation definitions.
    task automatic model(input logic e, input logic [3:0] o, input logic ci,
                         input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] r, output logic [3:0] f, output int lat);
        logic [15:0] yy;
        logic        cb, c, v;
        int          s, sv, n;
        logic [31:0] p;
        c = 1'b0; v = 1'b0; lat = 1; r = 16'h0;
        if (!e) begin
            case (o[3:2])
                2'd0: begin
                    yy = o[1] ? ~y : y;
                    cb = o[0] ? ci : o[1];
                    s  = int'(x) + int'(yy) + int'(cb);
                    sv = int'($signed(x)) + int'($signed(yy)) + int'(cb);
                    r  = s[15:0];
                    c  = (s > 65535);
                    v  = (sv > 32767) || (sv < -32768);
                end
                2'd1: begin
                    case (o[1:0])
                        2'd0: r = x & y;
                        2'd1: r = x | y;
                        2'd2: r = x ^ y;
                        default: r = x & ~y;
                    endcase
                end
                2'd2: begin
                    if (o[0]) r = (x >> 1) | (x & 16'h8000);
                    else      r = (x >> 1) | (ci ? 16'h8000 : 16'h0000);
                    c = x[0];
                end
                default: begin
                    case (o[1:0])
                        2'd0: r = y;
                        2'd1: r = {x[7:0], x[15:8]};
                        2'd2: r = x[7] ? (x | 16'hFF00) : (x & 16'h00FF);
                        default: r = ~x;
                    endcase
                end
            endcase
        end else if (o[1:0] == 2'd3) begin
            p   = {16'h0, x} * {16'h0, y};
            r   = p[15:0];
            c   = (p[31:16] != 0);
            lat = 17;
        end else begin
            n   = int'(y[3:0]);
            lat = n + 1;
            case (o[1:0])
                2'd0: begin r = 16'(x << n); c = (n > 0) ? x[16-n] : 1'b0; end
                2'd1: begin r = x >> n;      c = (n > 0) ? x[n-1]  : 1'b0; end
                default: begin r = 16'($signed(x) >>> n); c = (n > 0) ? x[n-1] : 1'b0; end
            endcase
        end
        f = {v, r[15], (r == 16'h0), c};
    endtask

    // Issue one op, scramble the inputs after accept, wait (bounded) for done.
    task automatic run_op(input logic e, input logic [3:0] o, input logic ci,
                          input logic [15:0] x, input logic [15:0] y,
                          output logic [15:0] r, output logic [3:0] f, output int lat);
        ext = e; op = o; cin = ci; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ext = 1'($urandom); op = 4'($urandom); cin = 1'($urandom);
        a = 16'($urandom); b = 16'($urandom);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        r = res; f = flags;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[19];
        logic [15:0] r, er;
        logic [3:0]  f, ef;
        int          lat, el, dones, dcyc;
        logic        e, ci;
        logic [3:0]  o;
        logic [15:0] x, y;

        tbl[0]  = '{1'b0, 4'b0000, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1100, 1};
        tbl[1]  = '{1'b0, 4'b0010, 1'b0, 16'h0005, 16'h0005, 16'h0000, 4'b0011, 1};
        tbl[2]  = '{1'b1, 4'b1101, 1'b0, 16'h00F0, 16'h0004, 16'h000F, 4'b0000, 5};
        tbl[3]  = '{1'b1, 4'b0000, 1'b0, 16'h1234, 16'h0000, 16'h1234, 4'b0000, 1};
        tbl[4]  = '{1'b1, 4'b0010, 1'b0, 16'h8001, 16'h0001, 16'hC000, 4'b0101, 2};
        tbl[5]  = '{1'b1, 4'b0011, 1'b0, 16'h0100, 16'h0101, 16'h0100, 4'b0001, 17};
        tbl[6]  = '{1'b1, 4'b0011, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 4'b0010, 17};
        tbl[7]  = '{1'b0, 4'b0100, 1'b0, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1};
        tbl[8]  = '{1'b0, 4'b1000, 1'b1, 16'h0003, 16'h0000, 16'h8001, 4'b0101, 1};
        tbl[9]  = '{1'b0, 4'b1001, 1'b0, 16'h8002, 16'h0000, 16'hC001, 4'b0100, 1};
        tbl[10] = '{1'b0, 4'b1101, 1'b0, 16'h12AB, 16'h0000, 16'hAB12, 4'b0100, 1};
        tbl[11] = '{1'b0, 4'b1110, 1'b0, 16'h0080, 16'h0000, 16'hFF80, 4'b0100, 1};
        tbl[12] = '{1'b0, 4'b1111, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 4'b0010, 1};
        tbl[13] = '{1'b0, 4'b1100, 1'b0, 16'h1234, 16'h0000, 16'h0000, 4'b0010, 1};
        tbl[14] = '{1'b0, 4'b0001, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 4'b0011, 1};
        tbl[15] = '{1'b0, 4'b0011, 1'b0, 16'h8000, 16'h0001, 16'h7FFE, 4'b1001, 1};
        tbl[16] = '{1'b0, 4'b0110, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0010, 1};
        tbl[17] = '{1'b0, 4'b0111, 1'b0, 16'hFF00, 16'h0F00, 16'hF000, 4'b0100, 1};
        tbl[18] = '{1'b1, 4'b0000, 1'b0, 16'h0003, 16'h000F, 16'h8000, 4'b0101, 16};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset res", 32'(res), 32'h0);
        check("reset flags", 32'(flags), 32'h0);
        check("reset ready", 32'(ready), 32'h1);
        check("reset done", 32'(done), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 19; i++) begin
            run_op(tbl[i].e, tbl[i].o, tbl[i].ci, tbl[i].x, tbl[i].y, r, f, lat);
            check($sformatf("vec%0d res", i), 32'(r), 32'(tbl[i].er));
            check($sformatf("vec%0d flags", i), 32'(f), 32'(tbl[i].ef));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].el));
            check($sformatf("vec%0d ready at done", i), 32'(ready), 32'h1);
        end

        // Back-to-back basic ops
        ext = 1'b0; op = 4'b0000; cin = 1'b0; a = 16'h7FFF; b = 16'h0001; start = 1'b1;
        @(posedge clk); #1;
        check("b2b add done", 32'(done), 32'h1);
        check("b2b add res", 32'(res), 32'h8000);
        check("b2b add flags", 32'(flags), 32'hC);
        op = 4'b0010; a = 16'h0005; b = 16'h0005;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b sub done", 32'(done), 32'h1);
        check("b2b sub res", 32'(res), 32'h0);
        check("b2b sub flags", 32'(flags), 32'h3);
        @(posedge clk); #1;
        check("b2b done drops", 32'(done), 32'h0);
        check("b2b flags hold", 32'(flags), 32'h3);

        // Start while busy is ignored
        ext = 1'b1; op = 4'b1101; a = 16'h00F0; b = 16'h0004; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy ready low", 32'(ready), 32'h0);
        dones = 0; dcyc = 0;
        for (int i = 2; i <= 10; i++) begin
            if (i == 2) begin
                ext = 1'b0; op = 4'b0000; a = 16'h0001; b = 16'h0001; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done === 1'b1) begin
                dones++;
                dcyc = i;
            end
        end
        check("busy done count", 32'(dones), 32'h1);
        check("busy done edge", 32'(dcyc), 32'h5);
        check("busy res", 32'(res), 32'h000F);
        check("busy flags", 32'(flags), 32'h0);

        // Randomized ops against the model
        for (int k = 0; k < 150; k++) begin
            e = 1'($urandom); o = 4'($urandom); ci = 1'($urandom);
            x = 16'($urandom); y = 16'($urandom);
            if (k % 10 == 0) x = 16'h8000;
            model(e, o, ci, x, y, er, ef, el);
            run_op(e, o, ci, x, y, r, f, lat);
            check($sformatf("rand%0d res", k), 32'(r), 32'(er));
            check($sformatf("rand%0d flags", k), 32'(f), 32'(ef));
            check($sformatf("rand%0d latency", k), 32'(lat), 32'(el));
        end

        // Reset in the middle of a multiply
        run_op(1'b0, 4'b0000, 1'b0, 16'h7FFF, 16'h0001, r, f, lat);
        check("pre-reset res", 32'(r), 32'h8000);
        ext = 1'b1; op = 4'b0011; a = 16'h0100; b = 16'h0101; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midop reset res", 32'(res), 32'h0);
        check("midop reset flags", 32'(flags), 32'h0);
        check("midop reset ready", 32'(ready), 32'h1);
        check("midop reset done", 32'(done), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        check("midop no done", 32'(dones), 32'h0);
        check("midop res holds 0", 32'(res), 32'h0);
        run_op(1'b0, 4'b0100, 1'b0, 16'hF0F0, 16'h0FF0, r, f, lat);
        check("post-reset and res", 32'(r), 32'h00F0);
        check("post-reset and flags", 32'(f), 32'h0);
        check("post-reset and latency", 32'(lat), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/mc_alu.md
Name: mc_alu

Overview:
Multi-cycle, parametrised successor to the single-cycle X-Makina ALU. It keeps the four op blocks (arithmetic, logic, 1-bit shifter, stray) as single-cycle registered operations. It adds an extended mode with iterative multi-bit shifts and a shift-add multiply. Sits in the execute stage of the multi-cycle core under a start/ready/done handshake, and provides registered result and C Z N V flags for the status register.

Parameters:
WORD, 16, datapath width in bits (even, >= 8)
SHW, $clog2(WORD), width of the shift-amount field taken from b

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  request; accepted only when ready=1
ext  in  1  0 = basic op, 1 = extended (iterative) op
op  in  4  operation select (see Behaviour)
cin  in  1  carry in (from status register)
a  in  WORD  operand A / shift source / multiplicand
b  in  WORD  operand B; b[SHW-1:0] = shift amount; multiplier
ready  out  1  high in IDLE
done  out  1  one-cycle pulse when res/flags updated
res  out  WORD  registered result
flags  out  4  registered {V,N,Z,C} (bit0=C, bit1=Z, bit2=N, bit3=V)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, res=0, flags=0, done=0, internal counters/accumulators 0; any op in flight is aborted and no done is produced.
- Operands, op, ext and cin are captured on accept (start & ready). Later input changes have no effect.
- Basic ops (ext=0). op[3:2] selects the block; latency 1 (res/flags/done on the next edge); ready stays 1, so back-to-back issue is allowed.
  - Arithmetic op[1:0]: 00 a+b; 01 a+b+cin; 10 a+~b+1; 11 a+~b+cin. C = carry out, V = signed overflow.
  - Logic: 00 AND; 01 OR; 10 XOR; 11 a&~b. C=0, V=0.
  - Shifter op[0]: 0 RRC {cin,a[W-1:1]}; 1 SRA {a[W-1],a[W-1:1]}. C=a[0], V=0.
  - Stray: 00 b; 01 byte-swap a; 10 sign-extend a[7:0]; 11 ~a. C=0, V=0.
- Extended ops (ext=1), op[1:0] (op[3:2] ignored):
  - 00 SHL, 01 SHR logical, 10 SAR. One bit per cycle for n=b[SHW-1:0] iterations. C = last bit shifted out (0 if n=0). V=0.
  - 11 MUL: unsigned shift-add, WORD iterations. res = low WORD bits of the product. C=1 iff the high WORD bits are nonzero. V=0.
- For all ops: Z = (res==0), N = res[WORD-1].
- FSM: IDLE -> RUN on an accepted extended op with iteration count > 0. RUN decrements the counter each cycle. On the cycle the counter reaches 0, res/flags are loaded and done pulses, and the FSM returns to IDLE (ready=1 the same cycle done=1).
  - Extended shift with n=0: completes like a basic op (latency 1, res=a, C=0).
  - Latency: shift = n+1 cycles, MUL = WORD+1 cycles, measured from the accept edge to the done edge.
- start while ready=0 is ignored; it is not queued.
- res/flags hold their value between done pulses. Flags update only on done.

Decomposition:
- Package mc_alu_pkg: block enum {ARITH, LOGIC, SHIFT, STRAY}; flag-bit enum {C,Z,N,V}; state enum {IDLE,RUN}; extended-op localparams {XSHL,XSHR,XSAR,XMUL}.
- One sub-module, mc_alu_iter: owns the shift/multiply accumulator, the iteration counter and the carry-out tracking. It takes load/step inputs and reports last-step, result and carry. The top level holds the FSM, the basic-op combinational logic and the output registers.

Test Plan (WORD=16):
- Reset: assert rst_n=0 mid-idle -> res=0x0000, flags=4'b0000, ready=1, done=0.
- Basic ADD: ext=0, op=0000, a=0x7FFF, b=0x0001 -> next edge done=1, res=0x8000, flags=4'b1100 (V,N). Back-to-back SUB op=0010, a=b=0x0005 the following cycle -> res=0x0000, flags=4'b0011 (Z,C).
- Extended SHR: ext=1, op=xx01, a=0x00F0, b=0x0004 -> ready=0 for 4 cycles, done on the 5th edge, res=0x000F, C=0. A start pulse during busy is ignored, with no extra done.
- Extended SHL with n=0: a=0x1234, b=0x0000 -> latency 1, res=0x1234, flags=4'b0000. SAR a=0x8001, b=1 -> res=0xC000, flags=4'b0101 (N,C).
- MUL: a=0x0100, b=0x0101 -> done 17 cycles after accept, res=0x0100, flags=4'b0001. MUL a=0, b=0xFFFF -> res=0, flags=4'b0010.
- Reset mid-op: start MUL, drop rst_n at cycle 8 -> immediately res=0, flags=0, ready=1, and no done is produced. After release, a basic AND of 0xF0F0 and 0x0FF0 -> res=0x00F0.
